tx_word_packer: RTL

Byte-to-word packer directly upstream of the RF command path. Accepts 8-bit bytes (UART receive side) under valid/ready and emits 32-bit words on the Tx_data/Tx_valid/Tx_ready interface consumed by the RF control state machine. Has a one-word output register plus a one-word assembly register, so byte intake continues while a finished word waits for the RF side. Partial words are flushed on an explicit request or, optionally, on an idle timeout.

---
 rtl/tx_word_packer_if.sv | 23 ++
 rtl/tx_word_packer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/tx_word_packer_if.sv
// Byte-in / word-out handshake bundle for tx_word_packer.
// The master drives bytes and the Tx_ready back-pressure; the slave is the packer.
interface tx_word_packer_if;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        flush;
    logic [31:0] Tx_data;
    logic        Tx_valid;
    logic        Tx_ready;
    logic [2:0]  Tx_bytes;
    logic        busy;

    modport master (
        output byte_data, byte_valid, flush, Tx_ready,
        input  byte_ready, Tx_data, Tx_valid, Tx_bytes, busy
    );

    modport slave (
        input  byte_data, byte_valid, flush, Tx_ready,
        output byte_ready, Tx_data, Tx_valid, Tx_bytes, busy
    );
endinterface

// File: rtl/tx_word_packer.sv
// Packs bytes MSB-lane-first into 32-bit words with a one-word output register.
// Optional idle auto-flush is enabled by defining TX_WORD_PACKER_TIMEOUT_EN.
module tx_word_packer #(
    parameter logic [7:0]  PAD_BYTE       = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic              clk,
    input logic              rst_n,
    tx_word_packer_if.slave  bus
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 32'h00FF_FFFF) begin : g_timeout_range
        $error("tx_word_packer: TIMEOUT_CYCLES must be within 2..2^24-1");
    end

    logic [31:0] r_asm_word;
    logic [2:0]  r_asm_cnt;
    logic        r_flush_pend;
    logic [31:0] r_tx_data;
    logic        r_tx_valid;
    logic [2:0]  r_tx_bytes;

    logic        w_byte_ready;
    logic        w_accept;
    logic [2:0]  w_cnt_eff;
    logic [31:0] w_word_eff;
    logic        w_slot_free;
    logic        w_load;
    logic        w_flush_req;
    logic        w_timeout;

    assign w_byte_ready = (r_asm_cnt < 3'd4) & ~r_flush_pend;
    assign w_accept     = bus.byte_valid & w_byte_ready;
    assign w_cnt_eff    = r_asm_cnt + {2'b00, w_accept};
    assign w_slot_free  = ~r_tx_valid | bus.Tx_ready;

    // The load sees the byte accepted at the same edge, so a 4th byte loads immediately.
    assign w_load      = ((w_cnt_eff == 3'd4) | r_flush_pend) & w_slot_free;
    assign w_flush_req = (bus.flush | w_timeout) & (w_cnt_eff != 3'd0) & (w_cnt_eff != 3'd4);

    always_comb begin
        w_word_eff = r_asm_word;
        if (w_accept) begin
            case (r_asm_cnt)
                3'd0:    w_word_eff[31:24] = bus.byte_data;
                3'd1:    w_word_eff[23:16] = bus.byte_data;
                3'd2:    w_word_eff[15:8]  = bus.byte_data;
                3'd3:    w_word_eff[7:0]   = bus.byte_data;
                default: w_word_eff = r_asm_word;
            endcase
        end
    end

`ifdef TX_WORD_PACKER_TIMEOUT_EN
    localparam logic [23:0] LP_IDLE_LAST = 24'(TIMEOUT_CYCLES - 1);

    logic [23:0] r_idle_cnt;
    logic        w_idle_run;

    assign w_idle_run = (r_asm_cnt != 3'd0) & (r_asm_cnt != 3'd4) & ~r_flush_pend;
    // A byte landing on the terminal cycle suppresses the auto-flush.
    assign w_timeout  = w_idle_run & ~w_accept & (r_idle_cnt == LP_IDLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (w_accept | w_load | w_timeout) begin
            r_idle_cnt <= '0;
        end else if (w_idle_run) begin
            r_idle_cnt <= r_idle_cnt + 24'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Unwritten lanes already hold PAD_BYTE, so a flushed word needs no extra fill step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm_word   <= {4{PAD_BYTE}};
            r_asm_cnt    <= 3'd0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_load) begin
                r_asm_word <= {4{PAD_BYTE}};
                r_asm_cnt  <= 3'd0;
            end else if (w_accept) begin
                r_asm_word <= w_word_eff;
                r_asm_cnt  <= w_cnt_eff;
            end

            if (w_load) begin
                r_flush_pend <= 1'b0;
            end else if (w_flush_req) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data  <= 32'd0;
            r_tx_valid <= 1'b0;
            r_tx_bytes <= 3'd0;
        end else if (w_load) begin
            r_tx_data  <= w_word_eff;
            r_tx_valid <= 1'b1;
            r_tx_bytes <= w_cnt_eff;
        end else if (bus.Tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign bus.byte_ready = w_byte_ready;
    assign bus.Tx_data    = r_tx_data;
    assign bus.Tx_valid   = r_tx_valid;
    assign bus.Tx_bytes   = r_tx_bytes;
    assign bus.busy       = (r_asm_cnt != 3'd0) | r_tx_valid;

endmodule
